draw_ball: RTL
==============

Name: draw_ball

Overview:
- Video pipeline stage directly downstream of the brick-drawing stage.
- Consumes its timing, rgb and brick-state outputs. Overlays the ball sprite and moves the ball once per frame.
- Detects wall, paddle and brick collisions. Reports destroyed bricks to the brick-state register as a one-cycle hit mask.
- Feeds the paddle/text stages with re-registered timing.

Parameters:
- BALL_SIZE, 10, ball square edge in pixels.
- BALL_COLOR, 12'hf_f_f, ball rgb.
- SPEED, 2, pixels moved per axis per frame.
- START_X, 395, ball x (left edge) while idle.
- START_Y, 500, ball y (top edge) while idle.
- SCREEN_W, 800, visible width.
- SCREEN_H, 600, visible height.
- PADDLE_Y, 560, paddle top row.
- PADDLE_W, 100, paddle width.
- GRID_X0, 100, left edge of brick column 0.
- GRID_Y0, 50, top edge of brick row 0.
- COL_PITCH, 150, x distance between brick columns.
- ROW_PITCH, 75, y distance between brick rows.
- B_WIDTH, 100, brick width.
- B_HEIGHT, 50, brick height.

Ports:
- pclk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hcount_in  in  11  horizontal counter
- hsync_in  in  1  hsync
- hblnk_in  in  1  hblank
- vcount_in  in  11  vertical counter
- vsync_in  in  1  vsync
- vblnk_in  in  1  vblank
- rgb_in  in  12  pixel from brick stage
- blocks_in  in  16  brick state; bit i=1 means brick i destroyed; i = row*4+col
- paddle_x_in  in  11  paddle left edge
- launch  in  1  level; starts ball from IDLE
- hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out  out  11/1/1/11/1/1  inputs delayed 1 cycle
- rgb_out  out  12  composited pixel
- block_hit  out  16  one-hot hit pulse, 1 cycle
- ball_lost  out  1  1-cycle pulse
- ball_x, ball_y  out  11 each  current ball position

Behaviour:
- Reset (async, active-high): all outputs 0 except ball_x=START_X and ball_y=START_Y; dx=+1, dy=-1 (up); state IDLE; vsync_prev=0.
- Pipeline: all timing outputs are the inputs registered once (latency 1).
- Pipeline: rgb_out = BALL_COLOR when hcount_in in [ball_x, ball_x+BALL_SIZE) and vcount_in in [ball_y, ball_y+BALL_SIZE), and neither blank is active. Otherwise rgb_out = rgb_in, also registered (latency 1).
- Frame tick = vsync_in high and vsync_prev low. Position registers update only on a tick, so the sprite is never torn within a frame.
- State IDLE: ball held at START. On a tick with launch=1 -> MOVE.
- State MOVE, on each tick, compute the candidate position nx = ball_x ± SPEED, ny = ball_y ± SPEED. Apply the first matching rule:
  1. ny+BALL_SIZE >= SCREEN_H -> LOST.
  2. Paddle: dy down, ny+BALL_SIZE >= PADDLE_Y, and ball horizontally overlaps [paddle_x_in, paddle_x_in+PADDLE_W) -> dy=up, ny=PADDLE_Y-BALL_SIZE.
  3. Brick: ball centre (nx+BALL_SIZE/2, ny+BALL_SIZE/2) inside brick i with blocks_in[i]=0 -> go to HIT with that i. The lowest index wins; only one brick per frame. Flip dy; position not advanced this frame.
  4. Walls: nx<=0 -> dx=+ and x=0; nx+BALL_SIZE>=SCREEN_W -> dx=- and x=SCREEN_W-BALL_SIZE; ny<=0 -> dy=down and y=0. Walls are independent per axis; a corner flips both.
  5. Otherwise commit nx, ny.
- All arithmetic is 12-bit signed internally to detect underflow. Results are clamped into [0, SCREEN-BALL_SIZE].
- State HIT: block_hit = 1<<i for exactly one cycle -> MOVE. A brick already destroyed (bit set) never produces a hit.
- State LOST: ball_lost=1 for one cycle; position reset to START; dx=+, dy=- -> IDLE.
- launch is ignored outside IDLE.
- A tick while in HIT/LOST is impossible, since both last 1 cycle and ticks are a frame apart.
- Reset mid-frame returns to IDLE immediately. Outputs are 0 until the next clock edge after release.

Test Plan:
- Assert reset for 3 cycles, then release -> all timing outputs and rgb_out = 0; ball_x=395, ball_y=500; block_hit=0.
- IDLE with launch=0, hcount=400, vcount=505, blanks low, rgb_in=12'h888 -> rgb_out=12'hfff one cycle later. At hcount=405 (ball occupies 395..404) -> rgb_out=12'h888.
- launch=1 over 3 vsync rising edges -> ball_x=401, ball_y=494. Register values stay constant between ticks.
- Ball moving up, blocks_in=0, centre entering brick 12 (row 3, col 0) -> block_hit=16'h1000 for exactly 1 cycle and dy becomes down. Repeat with blocks_in=16'h1000 -> no hit, ball passes through.
- Ball at x=2 moving left at a tick -> ball_x=0 and dx=+. Ball at y=1 moving up with x=0 -> both directions flip.
- Paddle at 600 with the ball falling outside [600,700) -> ball_lost pulses once, ball returns to 395/500, state IDLE. Paddle at 350 -> bounce, ball_y=550, no ball_lost.

Source files
------------

// File: rtl/draw_ball_if.sv
// rtl/draw_ball_if.sv - video timing plus pixel bus between pipeline stages
interface draw_ball_if;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
  modport slave  (input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
endinterface

// File: rtl/draw_ball.sv
// rtl/draw_ball.sv - ball sprite overlay, per-frame motion and wall/paddle/brick collisions
module draw_ball #(
  parameter int          BALL_SIZE  = 10,
  parameter logic [11:0] BALL_COLOR = 12'hfff,
  parameter int          SPEED      = 2,
  parameter int          START_X    = 395,
  parameter int          START_Y    = 500,
  parameter int          SCREEN_W   = 800,
  parameter int          SCREEN_H   = 600,
  parameter int          PADDLE_Y   = 560,
  parameter int          PADDLE_W   = 100,
  parameter int          GRID_X0    = 100,
  parameter int          GRID_Y0    = 50,
  parameter int          COL_PITCH  = 150,
  parameter int          ROW_PITCH  = 75,
  parameter int          B_WIDTH    = 100,
  parameter int          B_HEIGHT   = 50
) (
  input  logic        pclk,
  input  logic        reset,
  draw_ball_if.slave  vin,
  draw_ball_if.master vout,
  input  logic [15:0] blocks_in,
  input  logic [10:0] paddle_x_in,
  input  logic        launch,
  output logic [15:0] block_hit,
  output logic        ball_lost,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y
);

  localparam logic signed [11:0] BS    = 12'(BALL_SIZE);
  localparam logic signed [11:0] SPD   = 12'(SPEED);
  localparam logic signed [11:0] SW    = 12'(SCREEN_W);
  localparam logic signed [11:0] SH    = 12'(SCREEN_H);
  localparam logic signed [11:0] PY    = 12'(PADDLE_Y);
  localparam logic signed [11:0] PW    = 12'(PADDLE_W);
  localparam logic signed [11:0] BW    = 12'(B_WIDTH);
  localparam logic signed [11:0] BH    = 12'(B_HEIGHT);
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - BALL_SIZE);
  localparam logic [10:0]        X0    = 11'(START_X);
  localparam logic [10:0]        Y0    = 11'(START_Y);

  typedef enum logic [1:0] {IDLE, MOVE, HIT, LOST} state_t;

  state_t      state_q, state_d;
  logic [10:0] ball_x_q, ball_x_d, ball_y_q, ball_y_d;
  logic        dx_neg_q, dx_neg_d, dy_down_q, dy_down_d;
  logic [3:0]  hit_idx_q, hit_idx_d;
  logic        vsync_prev_q, vsync_prev_d;
  logic [10:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic        hsync_q, hsync_d, hblnk_q, hblnk_d, vsync_q, vsync_d, vblnk_q, vblnk_d;
  logic [11:0] rgb_q, rgb_d;

  logic              tick, in_ball, on_paddle, brick_found, do_move;
  logic [3:0]        brick_idx;
  logic signed [11:0] nx, ny, px, cx, cy;

  function automatic logic signed [11:0] brick_x(input int c);
    return 12'(GRID_X0 + c * COL_PITCH);
  endfunction

  function automatic logic signed [11:0] brick_y(input int r);
    return 12'(GRID_Y0 + r * ROW_PITCH);
  endfunction

  function automatic logic [10:0] clamp(input logic signed [11:0] v, input logic signed [11:0] hi);
    if (v < 12'sd0)   return '0;
    else if (v > hi)  return hi[10:0];
    else              return v[10:0];
  endfunction

  always_comb begin
    hcount_d     = vin.hcount;
    hsync_d      = vin.hsync;
    hblnk_d      = vin.hblnk;
    vcount_d     = vin.vcount;
    vsync_d      = vin.vsync;
    vblnk_d      = vin.vblnk;
    vsync_prev_d = vin.vsync;
    in_ball = !vin.hblnk && !vin.vblnk &&
              ({1'b0, vin.hcount} >= {1'b0, ball_x_q}) &&
              ({1'b0, vin.hcount} <  {1'b0, ball_x_q} + 12'(BALL_SIZE)) &&
              ({1'b0, vin.vcount} >= {1'b0, ball_y_q}) &&
              ({1'b0, vin.vcount} <  {1'b0, ball_y_q} + 12'(BALL_SIZE));
    rgb_d = in_ball ? BALL_COLOR : vin.rgb;
  end

  // Candidate position and collision tests, evaluated every cycle but only used on a tick
  always_comb begin
    tick = vin.vsync && !vsync_prev_q;
    nx   = $signed({1'b0, ball_x_q}) + (dx_neg_q ? -SPD : SPD);
    ny   = $signed({1'b0, ball_y_q}) + (dy_down_q ? SPD : -SPD);
    px   = $signed({1'b0, paddle_x_in});
    cx   = nx + (BS >>> 1);
    cy   = ny + (BS >>> 1);
    on_paddle = dy_down_q && (ny + BS >= PY) && (nx + BS > px) && (nx - PW < px);
    brick_found = 1'b0;
    brick_idx   = '0;
    for (int i = 15; i >= 0; i--) begin
      if (!blocks_in[i] &&
          cx >= brick_x(i % 4) && cx < brick_x(i % 4) + BW &&
          cy >= brick_y(i / 4) && cy < brick_y(i / 4) + BH) begin
        brick_found = 1'b1;
        brick_idx   = 4'(i);
      end
    end
  end

  // The launching tick already advances the ball, so motion starts on that same frame
  always_comb begin
    state_d   = state_q;
    ball_x_d  = ball_x_q;
    ball_y_d  = ball_y_q;
    dx_neg_d  = dx_neg_q;
    dy_down_d = dy_down_q;
    hit_idx_d = hit_idx_q;
    do_move   = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && launch) begin
          state_d = MOVE;
          do_move = 1'b1;
        end
      end
      MOVE: do_move = tick;
      HIT:  state_d = MOVE;
      LOST: begin
        state_d   = IDLE;
        ball_x_d  = X0;
        ball_y_d  = Y0;
        dx_neg_d  = 1'b0;
        dy_down_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    if (do_move) begin
      if (ny + BS >= SH) begin
        state_d = LOST;
      end else if (on_paddle) begin
        dy_down_d = 1'b0;
        ball_y_d  = clamp(PY - BS, Y_MAX);
        ball_x_d  = clamp(nx, X_MAX);
      end else if (brick_found) begin
        state_d   = HIT;
        hit_idx_d = brick_idx;
        dy_down_d = !dy_down_q;
      end else begin
        if (nx <= 12'sd0) begin
          ball_x_d = '0;
          dx_neg_d = 1'b0;
        end else if (nx + BS >= SW) begin
          ball_x_d = clamp(X_MAX, X_MAX);
          dx_neg_d = 1'b1;
        end else begin
          ball_x_d = clamp(nx, X_MAX);
        end
        if (ny <= 12'sd0) begin
          ball_y_d  = '0;
          dy_down_d = 1'b1;
        end else begin
          ball_y_d = clamp(ny, Y_MAX);
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      ball_x_q     <= X0;
      ball_y_q     <= Y0;
      dx_neg_q     <= 1'b0;
      dy_down_q    <= 1'b0;
      hit_idx_q    <= '0;
      vsync_prev_q <= 1'b0;
      hcount_q     <= '0;
      hsync_q      <= 1'b0;
      hblnk_q      <= 1'b0;
      vcount_q     <= '0;
      vsync_q      <= 1'b0;
      vblnk_q      <= 1'b0;
      rgb_q        <= '0;
    end else begin
      state_q      <= state_d;
      ball_x_q     <= ball_x_d;
      ball_y_q     <= ball_y_d;
      dx_neg_q     <= dx_neg_d;
      dy_down_q    <= dy_down_d;
      hit_idx_q    <= hit_idx_d;
      vsync_prev_q <= vsync_prev_d;
      hcount_q     <= hcount_d;
      hsync_q      <= hsync_d;
      hblnk_q      <= hblnk_d;
      vcount_q     <= vcount_d;
      vsync_q      <= vsync_d;
      vblnk_q      <= vblnk_d;
      rgb_q        <= rgb_d;
    end
  end

  assign vout.hcount = hcount_q;
  assign vout.hsync  = hsync_q;
  assign vout.hblnk  = hblnk_q;
  assign vout.vcount = vcount_q;
  assign vout.vsync  = vsync_q;
  assign vout.vblnk  = vblnk_q;
  assign vout.rgb    = rgb_q;
  assign block_hit   = (state_q == HIT) ? (16'd1 << hit_idx_q) : 16'd0;
  assign ball_lost   = (state_q == LOST);
  assign ball_x      = ball_x_q;
  assign ball_y      = ball_y_q;

endmodule
